// File: rtl/cpu_core_mc_if.sv
// -----------------------------------------------------------------------------
// cpu_core_mc_if
// Bus bundle between the multi-cycle core and its surroundings: the external
// instruction memory (1-cycle read latency) and the IO store sink.
//
// Signals:
//   imem_addr  core -> imem   instruction fetch address (registered in core)
//   imem_data  imem -> core   instruction word, valid 1 cycle after imem_addr
//   io_valid   core -> sink   IO store pending
//   io_ready   sink -> core   IO sink accepts the pending store
//   io_addr    core -> sink   IO store address
//   io_data    core -> sink   IO store data
//
// Modports: master = core side, slave = memory / IO sink side.
// -----------------------------------------------------------------------------
interface cpu_core_mc_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 8
);
  localparam int INST_W = 4 + REG_AW + IMM_W;

  logic [IMM_W-1:0]  imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              io_valid;
  logic              io_ready;
  logic [IMM_W-1:0]  io_addr;
  logic [DATA_W-1:0] io_data;

  modport master (
    output imem_addr, io_valid, io_addr, io_data,
    input  imem_data, io_ready
  );

  modport slave (
    input  imem_addr, io_valid, io_addr, io_data,
    output imem_data, io_ready
  );
endinterface

// File: rtl/cpu_core_mc.sv
// -----------------------------------------------------------------------------
// cpu_core_mc
// Parametrised multi-cycle 16-bit-class demo CPU. Every instruction takes a
// FETCH cycle and an EXEC cycle (CPI = 2); stores into the IO window stall in
// IOWAIT until the IO sink accepts them. Data RAM (2**IMM_W words) is internal,
// instruction memory is external with a 1-cycle read latency.
//
// Ports:
//   clk       in   clock
//   nreset    in   synchronous, active-high reset
//   bus       master modport of cpu_core_mc_if (imem fetch + IO store handshake)
//   halted    out  core is in HALT
//   flag_eq   out  current equal flag
//
// Build option:
//   CPU_COND_JUMP_EN  adds an unsigned less-than flag set by CMP and lets JE
//                     select its condition through the ra field
//                     (0 = eq, 1 = lt, 2 = not eq, others = never taken).
//                     Undefined: JE jumps iff flag_eq. Port list is identical.
//
// Instruction word: {op[3:0], ra[REG_AW-1:0], imm[IMM_W-1:0]};
// rb is the top REG_AW bits of imm.
// -----------------------------------------------------------------------------
module cpu_core_mc #(
  parameter int               DATA_W  = 16,
  parameter int               REG_AW  = 3,
  parameter int               IMM_W   = 8,
  parameter logic [IMM_W-1:0] IO_BASE = 8'hF0
) (
  input  logic           clk,
  input  logic           nreset,
  cpu_core_mc_if.master  bus,
  output logic           halted,
  output logic           flag_eq
);

  localparam int INST_W = 4 + REG_AW + IMM_W;
  localparam int NREGS  = 2 ** REG_AW;
  localparam int NWORDS = 2 ** IMM_W;
  // Width of the immediate that LDL/LDH can deposit into a register.
  localparam int LO_W   = (IMM_W < DATA_W) ? IMM_W : DATA_W;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_IOWAIT = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_MOV = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
    OP_OR  = 4'h4, OP_SL  = 4'h5, OP_SR  = 4'h6, OP_SRA = 4'h7,
    OP_LDL = 4'h8, OP_LDH = 4'h9, OP_CMP = 4'hA, OP_JE  = 4'hB,
    OP_JMP = 4'hC, OP_LD  = 4'hD, OP_ST  = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  // Register-to-register ALU operations (MOV..SRA).
  function automatic logic [DATA_W-1:0] alu_result(
    input opcode_t           op_f,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] a_s;
    logic        [DATA_W-1:0] r;
    a_s = $signed(a);
    unique case (op_f)
      OP_MOV:  r = b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SL:   r = {a[DATA_W-2:0], 1'b0};
      OP_SR:   r = {1'b0, a[DATA_W-1:1]};
      OP_SRA:  r = a_s >>> 1;
      default: r = a;
    endcase
    return r;
  endfunction

  // LDL deposits the immediate in the low bits, LDH in the high bits;
  // the remaining register bits are kept.
  function automatic logic [DATA_W-1:0] load_imm(
    input logic              high,
    input logic [DATA_W-1:0] a,
    input logic [IMM_W-1:0]  imm_f
  );
    logic [DATA_W-1:0] r;
    r = a;
    if (high) r[DATA_W-1 -: LO_W] = imm_f[LO_W-1:0];
    else      r[LO_W-1:0]         = imm_f[LO_W-1:0];
    return r;
  endfunction

  // Architectural state
  state_t             state_q, state_d;
  logic [IMM_W-1:0]   pc_q, pc_d;
  logic [IMM_W-1:0]   imem_addr_q, imem_addr_d;
  logic               flag_eq_q, flag_eq_d;
  logic               io_valid_q, io_valid_d;
  logic [IMM_W-1:0]   io_addr_q, io_addr_d;
  logic [DATA_W-1:0]  io_data_q, io_data_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  ram_q  [NWORDS];

  // Write ports
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wd;
  logic               ram_we;
  logic [IMM_W-1:0]   ram_wa;
  logic [DATA_W-1:0]  ram_wd;

  // Decode
  opcode_t            op;
  logic [REG_AW-1:0]  ra, rb;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  a_val, b_val;
  logic [IMM_W-1:0]   pc_inc;
  logic               je_taken;

  assign op     = opcode_t'(bus.imem_data[INST_W-1 -: 4]);
  assign ra     = bus.imem_data[IMM_W +: REG_AW];
  assign imm    = bus.imem_data[IMM_W-1:0];
  assign rb     = imm[IMM_W-1 -: REG_AW];
  assign a_val  = regs_q[ra];
  assign b_val  = regs_q[rb];
  assign pc_inc = pc_q + 1'b1;   // wraps naturally at 2**IMM_W

`ifdef CPU_COND_JUMP_EN
  logic flag_lt_q, flag_lt_d;

  always_comb begin
    je_taken = 1'b0;
    if      (int'(ra) == 0) je_taken = flag_eq_q;
    else if (int'(ra) == 1) je_taken = flag_lt_q;
    else if (int'(ra) == 2) je_taken = !flag_eq_q;
  end
`else
  assign je_taken = flag_eq_q;
`endif

  // Next-state / datapath control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    imem_addr_d = imem_addr_q;
    flag_eq_d   = flag_eq_q;
`ifdef CPU_COND_JUMP_EN
    flag_lt_d   = flag_lt_q;
`endif
    io_valid_d  = io_valid_q;
    io_addr_d   = io_addr_q;
    io_data_d   = io_data_q;
    rf_we       = 1'b0;
    rf_wd       = a_val;
    ram_we      = 1'b0;
    ram_wa      = imm;
    ram_wd      = a_val;

    unique case (state_q)
      // imem_addr already holds pc here, so the memory returns the word
      // at the end of this cycle for EXEC to consume.
      S_FETCH: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (op)
          OP_MOV, OP_ADD, OP_SUB, OP_AND,
          OP_OR, OP_SL, OP_SR, OP_SRA: begin
            rf_we = 1'b1;
            rf_wd = alu_result(op, a_val, b_val);
          end
          OP_LDL: begin
            rf_we = 1'b1;
            rf_wd = load_imm(1'b0, a_val, imm);
          end
          OP_LDH: begin
            rf_we = 1'b1;
            rf_wd = load_imm(1'b1, a_val, imm);
          end
          OP_CMP: begin
            flag_eq_d = (a_val == b_val);
`ifdef CPU_COND_JUMP_EN
            flag_lt_d = (a_val < b_val);
`endif
          end
          OP_JE:  if (je_taken) pc_d = imm;
          OP_JMP: pc_d = imm;
          OP_LD: begin
            rf_we = 1'b1;
            rf_wd = ram_q[imm];
          end
          OP_ST: begin
            if (imm >= IO_BASE) begin
              // pc stays on the ST until the sink accepts the store.
              io_valid_d = 1'b1;
              io_addr_d  = imm;
              io_data_d  = a_val;
              pc_d       = pc_q;
              state_d    = S_IOWAIT;
            end else begin
              ram_we = 1'b1;
            end
          end
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
        // Present the next fetch address for the whole following FETCH cycle.
        imem_addr_d = pc_d;
      end

      S_IOWAIT: begin
        if (bus.io_ready) begin
          // The accepted IO store is also mirrored into RAM.
          ram_we      = 1'b1;
          ram_wa      = io_addr_q;
          ram_wd      = io_data_q;
          io_valid_d  = 1'b0;
          pc_d        = pc_inc;
          imem_addr_d = pc_inc;
          state_d     = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  // Control and architectural registers
  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      imem_addr_q <= '0;
      flag_eq_q   <= 1'b0;
`ifdef CPU_COND_JUMP_EN
      flag_lt_q   <= 1'b0;
`endif
      io_valid_q  <= 1'b0;
      io_addr_q   <= '0;
      io_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      flag_eq_q   <= flag_eq_d;
`ifdef CPU_COND_JUMP_EN
      flag_lt_q   <= flag_lt_d;
`endif
      io_valid_q  <= io_valid_d;
      io_addr_q   <= io_addr_d;
      io_data_q   <= io_data_d;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (nreset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[ra] <= rf_wd;
    end
  end

  // Data RAM
  always_ff @(posedge clk) begin
    if (nreset) begin
      for (int i = 0; i < NWORDS; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      ram_q[ram_wa] <= ram_wd;
    end
  end

  assign bus.imem_addr = imem_addr_q;
  assign bus.io_valid  = io_valid_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_data   = io_data_q;
  assign halted        = (state_q == S_HALT);
  assign flag_eq       = flag_eq_q;

endmodule
